// File: rtl/apb_uart_fifo.sv
// APB slave UART with TX/RX FIFOs, watermark and error interrupt, loopback.
// Zero-wait-state register file; PSLVERR flags TX overrun pushes and empty RX pops.
module apb_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RX_WMARK   = 8,
  parameter int unsigned TX_WMARK   = 2,
  parameter int unsigned BAUD_W     = 13
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic [4:0] PADDR,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       RX,
  output logic       TX,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       INTR
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_RXDATA = 3'd1;
  localparam logic [2:0] A_BAUDLO = 3'd2;
  localparam logic [2:0] A_BAUDHI = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_IER    = 3'd6;
  localparam logic [2:0] A_LEVEL  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  logic [2:0]        reg_sel;
  logic              setup_rd, acc, acc_wr, acc_rd;
  logic              unused_paddr;

  logic [5:0]        ctrl_q, ctrl_d;
  logic [BAUD_W-1:0] baud_q, baud_d, baud_cnt_q, baud_cnt_d;
  logic [2:0]        ier_q, ier_d;
  logic [15:0]       baud16;
  logic              bit8, par_en, odd, tx_en, rx_en, loopback;
  logic              tick, baud_run;

  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;

  uart_state_e       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]        tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic              tx_par_q, tx_par_d, rx_par_q, rx_par_d;
  logic [7:0]        tx_byte, rx_byte;
  logic [2:0]        last_bit;

  logic              rx_s1_q, rx_s2_q, rx_in;
  logic              rx_push_req, rx_perr_set, rx_ferr_set;
  logic              ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              status_clr;
  logic [7:0]        status, prdata_q, prdata_d;
  logic              tx_q, tx_d, txrdy_q, txrdy_d, rxrdy_q, rxrdy_d, intr_q, intr_d;
  logic [2:0]        irq_src;

  function automatic logic [3:0] sat4(input logic [CW-1:0] c);
    return (c > CW'(15)) ? 4'hF : 4'(c);
  endfunction

  assign reg_sel      = PADDR[4:2];
  assign unused_paddr = ^PADDR[1:0];
  assign setup_rd     = PSEL & ~PENABLE & ~PWRITE;
  assign acc          = PSEL & PENABLE;
  assign acc_wr       = acc & PWRITE;
  assign acc_rd       = acc & ~PWRITE;

  assign {loopback, rx_en, tx_en, odd, par_en, bit8} = ctrl_q;
  assign baud16   = 16'(baud_q);
  assign last_bit = bit8 ? 3'd7 : 3'd6;

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_push  = acc_wr & (reg_sel == A_TXDATA) & ~tx_full;
  assign rx_pop   = acc_rd & (reg_sel == A_RXDATA) & ~rx_empty;
  assign rx_push  = rx_push_req & ~rx_full;

  assign tx_byte  = bit8 ? tx_mem[tx_rp_q] : {1'b0, tx_mem[tx_rp_q][6:0]};
  assign rx_byte  = bit8 ? rx_sh_q : {1'b0, rx_sh_q[7:1]};
  assign rx_in    = loopback ? tx_q : rx_s2_q;

  assign PSLVERR = acc & ((PWRITE & (reg_sel == A_TXDATA) & tx_full) |
                          (~PWRITE & (reg_sel == A_RXDATA) & rx_empty));
  assign PREADY  = 1'b1;
  assign PRDATA  = prdata_q;
  assign TX      = tx_q;
  assign TXRDY   = txrdy_q;
  assign RXRDY   = rxrdy_q;
  assign INTR    = intr_q;

  // Baud tick every baud_val+1 cycles; keeps running to finish an in-flight TX frame.
  always_comb begin
    baud_run   = tx_en | rx_en | (tx_state_q != S_IDLE);
    baud_cnt_d = baud_cnt_q;
    tick       = 1'b0;
    if (!baud_run) begin
      baud_cnt_d = baud_q;
    end else if (baud_cnt_q == '0) begin
      tick       = 1'b1;
      baud_cnt_d = baud_q;
    end else begin
      baud_cnt_d = baud_cnt_q - BAUD_W'(1);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    ier_d  = ier_q;
    if (acc_wr) begin
      case (reg_sel)
        A_BAUDLO: baud_d = BAUD_W'({baud16[15:8], PWDATA});
        A_BAUDHI: baud_d = BAUD_W'({PWDATA, baud16[7:0]});
        A_CTRL:   ctrl_d = PWDATA[5:0];
        A_IER:    ier_d  = PWDATA[2:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    status   = {1'b0, ferr_q, perr_q, ovf_q, rx_full, ~rx_empty, tx_full, tx_empty};
    prdata_d = prdata_q;
    if (setup_rd) begin
      case (reg_sel)
        A_RXDATA: prdata_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
        A_BAUDLO: prdata_d = baud16[7:0];
        A_BAUDHI: prdata_d = baud16[15:8];
        A_CTRL:   prdata_d = {2'b00, ctrl_q};
        A_STATUS: prdata_d = status;
        A_IER:    prdata_d = {5'b00000, ier_q};
        A_LEVEL:  prdata_d = {sat4(tx_cnt_q), sat4(rx_cnt_q)};
        default:  prdata_d = 8'h00;
      endcase
    end
  end

  // FIFO occupancy, sticky error flags (set wins over read-clear) and interrupt.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    status_clr = acc_rd & (reg_sel == A_STATUS);
    ovf_d   = (rx_push_req & rx_full) | (ovf_q & ~status_clr);
    perr_d  = rx_perr_set | (perr_q & ~status_clr);
    ferr_d  = rx_ferr_set | (ferr_q & ~status_clr);
    txrdy_d = (tx_cnt_d != CW'(FIFO_DEPTH));
    rxrdy_d = (rx_cnt_d != '0);
    irq_src = {ovf_q | perr_q | ferr_q, tx_cnt_q <= CW'(TX_WMARK), rx_cnt_q >= CW'(RX_WMARK)};
    intr_d  = |(ier_q & irq_src);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_q     <= 6'h18;
      baud_q     <= '0;
      ier_q      <= '0;
      baud_cnt_q <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      prdata_q   <= '0;
      txrdy_q    <= 1'b1;
      rxrdy_q    <= 1'b0;
      intr_q     <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      ier_q      <= ier_d;
      baud_cnt_q <= baud_cnt_d;
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      prdata_q   <= prdata_d;
      txrdy_q    <= txrdy_d;
      rxrdy_q    <= rxrdy_d;
      intr_q     <= intr_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp_q] <= PWDATA;
    if (rx_push) rx_mem[rx_wp_q] <= rx_byte;
  end

  // TX FSM state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    if (tick) begin
      if (tx_state_q != S_IDLE) tx_tcnt_d = tx_tcnt_q + 4'd1;
      case (tx_state_q)
        S_IDLE: if (tx_en && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_sh_d    = tx_byte;
          tx_par_d   = (^tx_byte) ^ odd;
        end
        S_START:  if (tx_tcnt_q == 4'd15) tx_state_d = S_DATA;
        S_DATA: if (tx_tcnt_q == 4'd15) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == last_bit) tx_state_d = par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tx_tcnt_q == 4'd15) tx_state_d = S_STOP;
        S_STOP:   if (tx_tcnt_q == 4'd15) tx_state_d = S_IDLE;
        default:  tx_state_d = S_IDLE;
      endcase
    end
  end

  // TX pin follows the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_sh_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // RX FSM state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    if (!rx_en) begin
      rx_state_d = S_IDLE;
    end else if (tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
      case (rx_state_q)
        S_IDLE: begin
          rx_tcnt_d = '0;
          rx_bit_d  = '0;
          if (!rx_in) rx_state_d = S_START;
        end
        S_START: if (rx_tcnt_q == 4'd7) begin
          rx_tcnt_d  = '0;
          rx_state_d = rx_in ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tcnt_q == 4'd15) begin
          rx_sh_d  = {rx_in, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == last_bit) rx_state_d = par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_tcnt_q == 4'd15) begin
          rx_par_d   = rx_in;
          rx_state_d = S_STOP;
        end
        S_STOP:   if (rx_tcnt_q == 4'd15) rx_state_d = S_IDLE;
        default:  rx_state_d = S_IDLE;
      endcase
    end
  end

  // Stop-bit sample: push the byte whatever its errors, flag them alongside.
  always_comb begin
    rx_push_req = 1'b0;
    rx_perr_set = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_en && tick && (rx_state_q == S_STOP) && (rx_tcnt_q == 4'd15)) begin
      rx_push_req = 1'b1;
      rx_ferr_set = ~rx_in;
      rx_perr_set = par_en & (rx_par_q != ((^rx_byte) ^ odd));
    end
  end

endmodule
